// File: rtl/puf_challenge_sequencer_pkg.sv
// Shared types and default widths for the PUF challenge sequencer.
// State encoding is common to the top and any debug tooling.
package puf_challenge_sequencer_pkg;

    localparam int DEF_CHALLENGE_WIDTH  = 64;
    localparam int DEF_PDL_CONFIG_WIDTH = 64;
    localparam int DEF_RESPONSE_WIDTH   = 6;
    localparam int DEF_EVAL_COUNT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRST   = 3'd1,
        FIRE   = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Host-side command and result handshakes of the sequencer.
// master = host handler, slave = sequencer.
interface puf_challenge_sequencer_if #(
    parameter int CHALLENGE_WIDTH  = 64,
    parameter int PDL_CONFIG_WIDTH = 64,
    parameter int RESPONSE_WIDTH   = 6,
    parameter int EVAL_COUNT_WIDTH = 8
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [CHALLENGE_WIDTH-1:0]  cmd_challenge;
    logic [PDL_CONFIG_WIDTH-1:0] cmd_pdl_config;
    logic [EVAL_COUNT_WIDTH-1:0] cmd_evals;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [EVAL_COUNT_WIDTH-1:0] rsp_ones;
    logic                        rsp_majority;
    logic [RESPONSE_WIDTH-1:0]   rsp_raw_last;

    modport master (
        output cmd_valid, cmd_challenge, cmd_pdl_config, cmd_evals,
        input  cmd_ready,
        input  rsp_valid, rsp_ones, rsp_majority, rsp_raw_last,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_challenge, cmd_pdl_config, cmd_evals,
        output cmd_ready,
        output rsp_valid, rsp_ones, rsp_majority, rsp_raw_last,
        input  rsp_ready
    );
endinterface

// File: rtl/puf_challenge_sequencer_response_sync.sv
// Two-flop synchronizer bringing the asynchronous arbiter
// outputs (raw and xor) into the sequencer clock domain.
module puf_response_sync #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Sequences reset/trigger/sample rounds into the PUF datapath and
// returns the xor ones-count and majority bit to the host.
module puf_challenge_sequencer
    import puf_challenge_sequencer_pkg::*;
#(
    parameter int CHALLENGE_WIDTH  = DEF_CHALLENGE_WIDTH,
    parameter int PDL_CONFIG_WIDTH = DEF_PDL_CONFIG_WIDTH,
    parameter int RESPONSE_WIDTH   = DEF_RESPONSE_WIDTH,
    parameter int RESET_CYCLES     = 4,
    parameter int SETTLE_CYCLES    = 15,
    parameter int EVAL_COUNT_WIDTH = DEF_EVAL_COUNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    puf_challenge_sequencer_if.slave    bus,
    output logic [CHALLENGE_WIDTH-1:0]  puf_challenge,
    output logic [PDL_CONFIG_WIDTH-1:0] puf_pdl_config,
    output logic                        puf_reset,
    output logic                        puf_trigger,
    input  logic [RESPONSE_WIDTH-1:0]   puf_raw_response,
    input  logic                        puf_xor_response,
    output logic                        busy
);

    localparam int CW = $clog2(RESET_CYCLES + SETTLE_CYCLES + 1);
    localparam int EW = EVAL_COUNT_WIDTH;

    seq_state_t                  r_state;
    logic [CW-1:0]               r_cnt;
    logic [EW-1:0]               r_evals_total;
    logic [EW-1:0]               r_evals_left;
    logic [EW-1:0]               r_ones;
    logic                        r_majority;
    logic [RESPONSE_WIDTH-1:0]   r_raw_last;
    logic                        r_rsp_valid;
    logic                        r_puf_reset;
    logic                        r_puf_trigger;
    logic [CHALLENGE_WIDTH-1:0]  r_challenge;
    logic [PDL_CONFIG_WIDTH-1:0] r_pdl_config;

    logic [RESPONSE_WIDTH:0]     w_sync;
    logic                        w_xor_s;
    logic [RESPONSE_WIDTH-1:0]   w_raw_s;
    logic [EW-1:0]               w_ones_next;
    logic [EW:0]                 w_twice_ones;
    logic [EW:0]                 w_total_ext;
    logic                        w_majority;

    puf_response_sync #(
        .WIDTH (RESPONSE_WIDTH + 1)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async ({puf_xor_response, puf_raw_response}),
        .o_sync  (w_sync)
    );

    assign w_xor_s      = w_sync[RESPONSE_WIDTH];
    assign w_raw_s      = w_sync[RESPONSE_WIDTH-1:0];
    assign w_ones_next  = r_ones + EW'(w_xor_s);
    // one extra bit so 2*ones cannot wrap
    assign w_twice_ones = {w_ones_next, 1'b0};
    assign w_total_ext  = {1'b0, r_evals_total};
    assign w_majority   = (w_twice_ones > w_total_ext);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_evals_total <= '0;
            r_evals_left  <= '0;
            r_ones        <= '0;
            r_majority    <= 1'b0;
            r_raw_last    <= '0;
            r_rsp_valid   <= 1'b0;
            r_puf_reset   <= 1'b1;
            r_puf_trigger <= 1'b0;
            r_challenge   <= '0;
            r_pdl_config  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_challenge  <= bus.cmd_challenge;
                        r_pdl_config <= bus.cmd_pdl_config;
                        if (bus.cmd_evals == '0) begin
                            r_evals_total <= EW'(1);
                            r_evals_left  <= EW'(1);
                        end else begin
                            r_evals_total <= bus.cmd_evals;
                            r_evals_left  <= bus.cmd_evals;
                        end
                        r_ones  <= '0;
                        r_cnt   <= '0;
                        r_state <= PRST;
                    end
                end
                PRST: begin
                    if (r_cnt == CW'(RESET_CYCLES - 1)) begin
                        r_cnt         <= '0;
                        r_puf_reset   <= 1'b0;
                        r_puf_trigger <= 1'b1;
                        r_state       <= FIRE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                FIRE: begin
                    if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                SAMPLE: begin
                    r_ones        <= w_ones_next;
                    r_raw_last    <= w_raw_s;
                    r_puf_trigger <= 1'b0;
                    r_puf_reset   <= 1'b1;
                    if (r_evals_left == EW'(1)) begin
                        r_majority  <= w_majority;
                        r_rsp_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_evals_left <= r_evals_left - EW'(1);
                        r_state      <= PRST;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready    = (r_state == IDLE);
    assign busy             = (r_state != IDLE);
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_ones     = r_ones;
    assign bus.rsp_majority = r_majority;
    assign bus.rsp_raw_last = r_raw_last;
    assign puf_challenge    = r_challenge;
    assign puf_pdl_config   = r_pdl_config;
    assign puf_reset        = r_puf_reset;
    assign puf_trigger      = r_puf_trigger;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer with a result
// scoreboard, latency and trigger-spacing checks.
module tb_puf_challenge_sequencer;

    typedef struct packed {
        logic [7:0] ones;
        logic       maj;
        logic [5:0] raw;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [63:0] puf_challenge;
    logic [63:0] puf_pdl_config;
    logic        puf_reset;
    logic        puf_trigger;
    logic [5:0]  puf_raw_response;
    logic        puf_xor_response;
    logic        busy;

    int   checks;
    int   failures;
    exp_t sb[$];

    puf_challenge_sequencer_if #(
        .CHALLENGE_WIDTH  (64),
        .PDL_CONFIG_WIDTH (64),
        .RESPONSE_WIDTH   (6),
        .EVAL_COUNT_WIDTH (8)
    ) bus ();

    puf_challenge_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .puf_challenge    (puf_challenge),
        .puf_pdl_config   (puf_pdl_config),
        .puf_reset        (puf_reset),
        .puf_trigger      (puf_trigger),
        .puf_raw_response (puf_raw_response),
        .puf_xor_response (puf_xor_response),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, feed xor pattern bit i on the i-th trigger
    // rise, and check the result against the scoreboard head.
    task automatic run_cmd(input logic [7:0] evals,
                           input logic [15:0] pat,
                           input logic [5:0] raw,
                           input logic [63:0] ch,
                           input logic [63:0] cfg,
                           input bit release_rsp);
        int   n;
        int   ones;
        int   cyc;
        int   trigs;
        int   rcnt;
        int   min_rcnt;
        logic prev;
        exp_t e;
        exp_t got;
        n    = (evals == 0) ? 1 : int'(evals);
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(pat[i]);
        e.ones = 8'(ones);
        e.maj  = (2 * ones > n);
        e.raw  = raw;
        sb.push_back(e);

        @(negedge clk);
        bus.cmd_valid      = 1'b1;
        bus.cmd_challenge  = ch;
        bus.cmd_pdl_config = cfg;
        bus.cmd_evals      = evals;
        @(posedge clk);
        #1;
        bus.cmd_valid      = 1'b0;
        bus.cmd_challenge  = ~ch;
        bus.cmd_pdl_config = ~cfg;
        bus.cmd_evals      = 8'd7;

        cyc      = 0;
        trigs    = 0;
        rcnt     = 0;
        min_rcnt = 1000;
        prev     = 1'b0;
        forever begin
            @(negedge clk);
            if (puf_trigger && !prev) begin
                if (rcnt < min_rcnt) min_rcnt = rcnt;
                if (trigs < 16) puf_xor_response = pat[trigs];
                puf_raw_response = raw;
                trigs++;
                rcnt = 0;
            end
            if (puf_reset && !puf_trigger) rcnt++;
            prev = puf_trigger;
            if (bus.rsp_valid) break;
            if (cyc > 20 * n + 50) begin
                chk("rsp_timeout", 64'(cyc), 64'(20 * n));
                break;
            end
            @(posedge clk);
            cyc++;
        end

        chk("latency", 64'(cyc), 64'(20 * n));
        chk("trig_count", 64'(trigs), 64'(n));
        chk("rst_hold_ok", 64'(min_rcnt >= 4), 64'd1);
        chk("puf_challenge", puf_challenge, ch);
        chk("puf_pdl_config", puf_pdl_config, cfg);
        e = sb.pop_front();
        got.ones = bus.rsp_ones;
        got.maj  = bus.rsp_majority;
        got.raw  = bus.rsp_raw_last;
        chk("rsp_ones", 64'(got.ones), 64'(e.ones));
        chk("rsp_majority", 64'(got.maj), 64'(e.maj));
        chk("rsp_raw_last", 64'(got.raw), 64'(e.raw));
        chk("cmd_ready_done", 64'(bus.cmd_ready), 64'd0);

        if (release_rsp) begin
            @(posedge clk);
            #1;
            chk("rsp_valid_clr", 64'(bus.rsp_valid), 64'd0);
            chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
        end
    endtask

    initial begin
        logic [7:0] h_ones;
        logic       h_maj;
        logic [5:0] h_raw;
        bit         stable;
        bit         stale;
        bit         fired;

        checks             = 0;
        failures           = 0;
        reset              = 1'b1;
        bus.cmd_valid      = 1'b0;
        bus.cmd_challenge  = '0;
        bus.cmd_pdl_config = '0;
        bus.cmd_evals      = '0;
        bus.rsp_ready      = 1'b1;
        puf_raw_response   = '0;
        puf_xor_response   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_puf_reset", 64'(puf_reset), 64'd1);
        chk("rst_trigger", 64'(puf_trigger), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_ones", 64'(bus.rsp_ones), 64'd0);
        chk("rst_majority", 64'(bus.rsp_majority), 64'd0);
        chk("rst_raw_last", 64'(bus.rsp_raw_last), 64'd0);
        chk("rst_challenge", puf_challenge, 64'd0);
        chk("rst_pdl", puf_pdl_config, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;

        run_cmd(8'd1, 16'h0001, 6'b101101,
                64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b1);
        run_cmd(8'd5, 16'b01101, 6'b010011,
                64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_0F0F_F0F0_F0F0, 1'b1);
        run_cmd(8'd4, 16'b0011, 6'b111000,
                64'hCAFE_F00D_0000_0001, 64'h8000_0000_0000_0001, 1'b1);
        run_cmd(8'd0, 16'h0001, 6'b000111,
                64'h0000_0000_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 1'b1);

        // Result backpressure with an ignored second command.
        bus.rsp_ready = 1'b0;
        run_cmd(8'd1, 16'h0000, 6'b110011,
                64'hDEAD_BEEF_0123_4567, 64'h5555_AAAA_5555_AAAA, 1'b0);
        h_ones = bus.rsp_ones;
        h_maj  = bus.rsp_majority;
        h_raw  = bus.rsp_raw_last;
        stable = 1'b1;
        bus.cmd_valid      = 1'b1;
        bus.cmd_challenge  = 64'h7777_8888_9999_AAAA;
        bus.cmd_evals      = 8'd2;
        puf_xor_response   = 1'b1;
        puf_raw_response   = 6'b001100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_ones !== h_ones ||
                bus.rsp_majority !== h_maj ||
                bus.rsp_raw_last !== h_raw || bus.cmd_ready !== 1'b0 ||
                puf_challenge !== 64'hDEAD_BEEF_0123_4567)
                stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        chk("bp_ones_held", 64'(bus.rsp_ones), 64'd0);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rsp_valid_clr", 64'(bus.rsp_valid), 64'd0);
        chk("bp_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("bp_chal_kept", puf_challenge, 64'hDEAD_BEEF_0123_4567);

        // Reset asserted while the trigger is high.
        @(negedge clk);
        bus.cmd_valid     = 1'b1;
        bus.cmd_challenge = 64'hFEED_FACE_0000_0000;
        bus.cmd_evals     = 8'd1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        fired = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (puf_trigger) begin
                fired = 1'b1;
                break;
            end
        end
        chk("fire_reached", 64'(fired), 64'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ar_trigger", 64'(puf_trigger), 64'd0);
        chk("ar_puf_reset", 64'(puf_reset), 64'd1);
        chk("ar_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("ar_challenge", puf_challenge, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.rsp_valid || busy || puf_trigger) stale = 1'b1;
        end
        chk("ar_no_stale", 64'(stale), 64'd0);
        chk("ar_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        run_cmd(8'd3, 16'b111, 6'b100001,
                64'h0F1E_2D3C_4B5A_6978, 64'h0, 1'b1);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/puf_challenge_sequencer.md
Name: puf_challenge_sequencer

Overview:
- Initiator side of the PUF evaluation path. Accepts a challenge command from the host-side handler.
- Drives challenge, PDL config, PUF reset and trigger into the PUF datapath, and repeats the evaluation N times.
- Samples the synchronized XOR/raw responses, then returns a ones-count and majority bit to the host over a valid/ready handshake.
- Sits between the host handler and the PUF mapping/interconnect block.

Parameters:
- CHALLENGE_WIDTH, 64, challenge bits per command
- PDL_CONFIG_WIDTH, 64, PDL configuration bits per command
- RESPONSE_WIDTH, 6, raw arbiter response bits
- RESET_CYCLES, 4, cycles puf_reset is held high before each trigger (>=1)
- SETTLE_CYCLES, 15, cycles puf_trigger is held high before sampling (>=3; covers sync latency)
- EVAL_COUNT_WIDTH, 8, width of repeat count and ones counter

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_challenge  in  CHALLENGE_WIDTH  challenge to evaluate
- cmd_pdl_config  in  PDL_CONFIG_WIDTH  delay-line configuration
- cmd_evals  in  EVAL_COUNT_WIDTH  number of evaluations (0 treated as 1)
- puf_challenge  out  CHALLENGE_WIDTH  latched challenge to PUF
- puf_pdl_config  out  PDL_CONFIG_WIDTH  latched config to PUF
- puf_reset  out  1  clears PUF arbiters
- puf_trigger  out  1  launch edge to PUF
- puf_raw_response  in  RESPONSE_WIDTH  asynchronous arbiter outputs
- puf_xor_response  in  1  asynchronous XOR of raw outputs
- rsp_valid  out  1  result available
- rsp_ready  in  1  host consumes result
- rsp_ones  out  EVAL_COUNT_WIDTH  number of evaluations with xor=1
- rsp_majority  out  1  majority xor bit
- rsp_raw_last  out  RESPONSE_WIDTH  raw response of final evaluation
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state IDLE, cmd_ready=1, puf_reset=1, puf_trigger=0, rsp_valid=0, rsp_ones=0, rsp_majority=0, rsp_raw_last=0, puf_challenge=0, puf_pdl_config=0, busy=0, internal counters=0.
- Outputs are registered except cmd_ready=(state==IDLE) and busy=(state!=IDLE).
- States:
  - IDLE: puf_reset=1, trigger=0. On cmd_valid&cmd_ready, latch challenge, config and evals (0->1), clear ones counter, go PRST.
  - PRST: puf_reset=1, trigger=0 for RESET_CYCLES cycles, then go FIRE.
  - FIRE: puf_reset=0, trigger=1 for SETTLE_CYCLES cycles, then go SAMPLE.
  - SAMPLE: one cycle, trigger still 1. Capture synced xor, add it to the ones counter, capture synced raw into rsp_raw_last. If evals remain, go PRST; else go DONE.
  - DONE: rsp_valid=1, puf_reset=1, trigger=0. rsp_* are held stable until rsp_valid&rsp_ready, then go IDLE.
- Latency: rsp_valid rises exactly N*(RESET_CYCLES+SETTLE_CYCLES+1) cycles after the accepting edge. With defaults and N=1, that is 20 cycles.
- puf_challenge and puf_pdl_config change only on command acceptance and are stable through all N evaluations.
- Majority: rsp_majority=1 iff 2*ones > N (strict). A tie gives 0. Compute at EVAL_COUNT_WIDTH+1 bits, with no overflow.
- cmd_valid in any state other than IDLE is ignored (cmd_ready=0).
- Asynchronous reset mid-operation forces the reset values immediately. Any in-flight command and its result are discarded.
- The trigger rising edge occurs only after at least RESET_CYCLES cycles of puf_reset=1.

Decomposition:
- Shared package: state encoding (IDLE, PRST, FIRE, SAMPLE, DONE) and default width constants (64/64/6).
- Sub-module puf_response_sync: a 2-flop synchronizer on RESPONSE_WIDTH+1 bits (raw and xor).
  - Same clock and asynchronous reset; resets to 0.

Test Plan:
- Evals=1, xor tied 1, raw=6'b101101 -> rsp_valid 20 cycles after accept; ones=1, majority=1, raw_last=6'b101101.
- Evals=5, xor per evaluation 1,0,1,1,0 -> ones=3, majority=1. The trigger rises 5 times, each after 4 reset cycles.
- Evals=4, xor pattern 1,1,0,0 -> ones=2, majority=0 (tie). Evals=0 -> behaves as 1 (one trigger pulse, 20-cycle latency).
- Result backpressure: rsp_ready low 10 cycles after rsp_valid -> rsp_* stable; cmd_ready=0, and a new cmd_valid is ignored until the handshake completes.
- Assert reset during FIRE -> puf_trigger=0 and puf_reset=1 the same cycle; rsp_valid=0; after release, cmd_ready=1 and no stale result.
- Command stability: change cmd_challenge after acceptance -> puf_challenge keeps the latched value (e.g. 64'hDEADBEEF_01234567) until the next acceptance.
